writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 13 +
 rtl/wb_fifo2.sv | 45 ++++
 rtl/writeback_arbiter.sv | 106 ++++++++++
 tb/tb_writeback_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared core types and width defaults for writeback arbitration
package writeback_arbiter_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LD
  } wb_src_e;

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry load buffer with wrapping pointers and occupancy count
module wb_fifo2 #(
  parameter int WIDTH = 37
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic [1:0]       count_next
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage carries no reset; count alone decides what is valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
    end
  end

  assign count_next = count + {1'b0, push} - {1'b0, pop};
  assign head       = mem[rd_ptr];

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write port arbitration between ALU results and buffered loads
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = WB_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  AluValid,
  input  logic [ADDR_WIDTH-1:0] AluRd,
  input  logic [DATA_WIDTH-1:0] AluData,
  input  logic                  LdValid,
  output logic                  LdReady,
  input  logic [ADDR_WIDTH-1:0] LdRd,
  input  logic [DATA_WIDTH-1:0] LdData,
  output logic                  AluStall,
  output logic                  LdPending,
  output logic                  WrEn,
  output logic [ADDR_WIDTH-1:0] WrAddr,
  output logic [DATA_WIDTH-1:0] WrData
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
  logic [1:0]                       count;
  logic [1:0]                       count_next;
  logic                             push;
  logic                             pop;
  logic                             blocked;
  logic [SW-1:0]                    starve_cnt;
  wb_src_e                          win;
  logic [ADDR_WIDTH-1:0]            win_rd;
  logic [DATA_WIDTH-1:0]            win_data;

  // Ready depends only on the registered count, so a full FIFO stays closed even while popping.
  assign LdReady = (count < 2'd2);
  assign push    = LdValid && LdReady;

  wb_fifo2 #(
    .WIDTH(ADDR_WIDTH + DATA_WIDTH)
  ) u_fifo (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .push      (push),
    .push_data ({LdRd, LdData}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .count_next(count_next)
  );

  // ALU has no backpressure, so it always wins; a stall only makes room for loads.
  always_comb begin
    win      = WB_NONE;
    win_rd   = '0;
    win_data = '0;
    if (AluValid) begin
      win      = WB_ALU;
      win_rd   = AluRd;
      win_data = AluData;
    end else if (count != 2'd0) begin
      win      = WB_LD;
      win_rd   = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
      win_data = head[DATA_WIDTH-1:0];
    end
  end

  assign pop     = (win == WB_LD);
  assign blocked = (win == WB_ALU) && (count != 2'd0);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      starve_cnt <= '0;
      AluStall   <= 1'b0;
      LdPending  <= 1'b0;
    end else begin
      if (pop) begin
        starve_cnt <= '0;
      end else if (blocked && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      AluStall  <= !pop && (starve_cnt == STARVE_MAX);
      LdPending <= (count_next != 2'd0);
    end
  end

  // x0 is consumed silently; address and data hold when nothing is written.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      WrEn   <= 1'b0;
      WrAddr <= '0;
      WrData <= '0;
    end else begin
      WrEn <= (win != WB_NONE) && (win_rd != '0);
      if ((win != WB_NONE) && (win_rd != '0)) begin
        WrAddr <= win_rd;
        WrData <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench with a queue-based reference model
module tb_writeback_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic          Clk;
  logic          ResetN;
  logic          AluValid;
  logic [AW-1:0] AluRd;
  logic [DW-1:0] AluData;
  logic          LdValid;
  logic          LdReady;
  logic [AW-1:0] LdRd;
  logic [DW-1:0] LdData;
  logic          AluStall;
  logic          LdPending;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [DW-1:0] WrData;

  writeback_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .AluValid (AluValid),
    .AluRd    (AluRd),
    .AluData  (AluData),
    .LdValid  (LdValid),
    .LdReady  (LdReady),
    .LdRd     (LdRd),
    .LdData   (LdData),
    .AluStall (AluStall),
    .LdPending(LdPending),
    .WrEn     (WrEn),
    .WrAddr   (WrAddr),
    .WrData   (WrData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } ld_t;

  ld_t           q[$];
  int            starve;
  logic          m_stall;
  logic          m_wren;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  // Reference: ALU always writes; otherwise the oldest buffered load; x0 discarded.
  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      q.delete();
      starve  = 0;
      m_stall = 1'b0;
      m_wren  = 1'b0;
      m_addr  = '0;
      m_data  = '0;
    end else begin
      bit            acc;
      bit            popped;
      bit            has;
      int            prev;
      ld_t           h;
      ld_t           incoming;
      logic [AW-1:0] wrd;
      logic [DW-1:0] wd;
      acc      = LdValid && (q.size() < 2);
      incoming.rd = LdRd;
      incoming.d  = LdData;
      prev   = starve;
      popped = 0;
      has    = 0;
      wrd    = '0;
      wd     = '0;
      if (AluValid) begin
        has = 1;
        wrd = AluRd;
        wd  = AluData;
        if (q.size() != 0 && starve < LIMIT) starve++;
      end else if (q.size() != 0) begin
        h      = q.pop_front();
        has    = 1;
        wrd    = h.rd;
        wd     = h.d;
        popped = 1;
        starve = 0;
      end
      m_stall = !popped && (prev == LIMIT);
      m_wren  = has && (wrd != 0);
      if (m_wren) begin
        m_addr = wrd;
        m_data = wd;
      end
      if (acc) q.push_back(incoming);
    end
  end

  always @(negedge Clk) begin
    if (chk_en && ResetN) begin
      cmp("model_wren", WrEn, m_wren);
      cmp("model_addr", WrAddr, m_addr);
      cmp("model_data", WrData, m_data);
      cmp("model_ldready", LdReady, q.size() < 2);
      cmp("model_ldpending", LdPending, q.size() != 0);
      cmp("model_alustall", AluStall, m_stall);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    AluValid = v;
    AluRd    = rd;
    AluData  = d;
  endtask

  task automatic set_ld(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    LdValid = v;
    LdRd    = rd;
    LdData  = d;
  endtask

  int wr_pulses;

  initial begin
    ResetN = 1'b0;
    set_alu(0, '0, '0);
    set_ld(0, '0, '0);
    repeat (2) tick();
    ResetN = 1'b1;
    chk_en = 1;
    cmp("reset_ldready", LdReady, 1);
    cmp("reset_wren", WrEn, 0);
    cmp("reset_ldpending", LdPending, 0);
    cmp("reset_alustall", AluStall, 0);

    // Single load, no ALU traffic
    set_ld(1, 5, 32'hDEAD0001);
    tick();
    set_ld(0, 0, 0);
    cmp("ld_lat1_wren", WrEn, 0);
    cmp("ld_lat1_pending", LdPending, 1);
    tick();
    cmp("ld_lat2_wren", WrEn, 1);
    cmp("ld_lat2_addr", WrAddr, 5);
    cmp("ld_lat2_data", WrData, 32'hDEAD0001);
    cmp("ld_lat2_pending", LdPending, 0);
    tick();

    // ALU and load offered together
    set_alu(1, 3, 32'h11);
    set_ld(1, 7, 32'h22);
    tick();
    set_alu(0, 0, 0);
    set_ld(0, 0, 0);
    cmp("same_alu_addr", WrAddr, 3);
    cmp("same_alu_data", WrData, 32'h11);
    tick();
    cmp("same_ld_addr", WrAddr, 7);
    cmp("same_ld_data", WrData, 32'h22);
    tick();
    cmp("hold_wren", WrEn, 0);
    cmp("hold_addr", WrAddr, 7);

    // Back-to-back loads starved by continuous ALU traffic
    set_alu(1, 1, 32'hA0);
    set_ld(1, 10, 32'hB0);
    tick();
    set_alu(1, 1, 32'hA1);
    set_ld(1, 11, 32'hB1);
    tick();
    cmp("starve_ldready_full", LdReady, 0);
    set_ld(1, 12, 32'hB2);
    for (int i = 2; i < 5; i++) begin
      set_alu(1, 1, 32'hA0 + i);
      tick();
    end
    cmp("starve_no_stall_yet", AluStall, 0);
    set_alu(1, 1, 32'hA5);
    tick();
    cmp("starve_stall_high", AluStall, 1);
    set_alu(0, 0, 0);
    tick();
    cmp("drain0_data", WrData, 32'hB0);
    cmp("drain0_stall_low", AluStall, 0);
    tick();
    set_ld(0, 0, 0);
    cmp("drain1_data", WrData, 32'hB1);
    tick();
    cmp("drain2_data", WrData, 32'hB2);
    tick();
    cmp("drain_done_pending", LdPending, 0);

    // x0 writes are consumed silently
    set_alu(1, 0, 32'hFFFFFFFF);
    tick();
    set_alu(0, 0, 0);
    cmp("x0_alu_wren", WrEn, 0);
    cmp("x0_alu_data_hold", WrData, 32'hB2);
    set_ld(1, 0, 32'h33);
    tick();
    set_ld(0, 0, 0);
    cmp("x0_ld_pending", LdPending, 1);
    tick();
    cmp("x0_ld_wren", WrEn, 0);
    cmp("x0_ld_popped", LdPending, 0);
    tick();

    // Full FIFO plus ALU during stall
    set_alu(1, 2, 32'hC0);
    set_ld(1, 20, 32'hD0);
    tick();
    set_ld(1, 21, 32'hD1);
    tick();
    set_ld(0, 0, 0);
    repeat (4) tick();
    cmp("viol_stall_high", AluStall, 1);
    set_alu(1, 9, 32'hC9);
    tick();
    cmp("viol_alu_addr", WrAddr, 9);
    cmp("viol_alu_data", WrData, 32'hC9);
    cmp("viol_stall_held", AluStall, 1);
    set_alu(0, 0, 0);
    tick();
    cmp("viol_ld0_data", WrData, 32'hD0);
    tick();
    cmp("viol_ld1_data", WrData, 32'hD1);
    tick();

    // Asynchronous reset with two loads buffered
    set_alu(1, 4, 32'hE0);
    set_ld(1, 30, 32'hF0);
    tick();
    set_ld(1, 31, 32'hF1);
    tick();
    set_ld(0, 0, 0);
    set_alu(0, 0, 0);
    cmp("prerst_pending", LdPending, 1);
    #2;
    ResetN = 1'b0;
    #1;
    cmp("rst_wren", WrEn, 0);
    cmp("rst_addr", WrAddr, 0);
    cmp("rst_data", WrData, 0);
    cmp("rst_pending", LdPending, 0);
    cmp("rst_stall", AluStall, 0);
    tick();
    ResetN = 1'b1;
    wr_pulses = 0;
    repeat (4) begin
      tick();
      if (WrEn) wr_pulses++;
    end
    cmp("rst_no_stale_write", wr_pulses, 0);
    cmp("rst_after_pending", LdPending, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
